qam_mapper: RTL and testbench

Upstream neighbour of the 64-point FFT input register. Takes a serial bit stream with a valid/ready handshake and groups bits per symbol by modulation mode. Gray-maps each group to a signed 16-bit I/Q constellation point (Q1.14). Emits exactly 64 subcarrier values per OFDM frame on outx/outy with a one-cycle mod_en strobe, inserting zero-valued null subcarriers without consuming bits.

---
 rtl/ofdm_pkg.sv | 33 +++
 rtl/qam_mapper_if.sv | 22 ++
 rtl/qam_lut.sv | 42 ++++
 rtl/qam_mapper.sv | 105 ++++++++++
 tb/tb_qam_mapper.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions: modulation encodings, constellation amplitudes and
// the null-subcarrier layout of the 64-point frame.
package ofdm_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  localparam int FFT_N   = 64;
  localparam int NULL_LO = 27;
  localparam int NULL_HI = 37;

  localparam logic signed [15:0] AMP_BPSK_DEF  = 16'sd16384;
  localparam logic signed [15:0] AMP_QPSK_DEF  = 16'sd11585;
  localparam logic signed [15:0] AMP_QAM16_DEF = 16'sd5181;

  // The reserved mode behaves exactly like QPSK.
  function automatic logic [2:0] bits_per_symbol(mode_t m);
    case (m)
      MODE_BPSK:  return 3'd1;
      MODE_QAM16: return 3'd4;
      default:    return 3'd2;
    endcase
  endfunction

  function automatic logic is_null_idx(logic [5:0] idx);
    return (idx == 6'd0) || ((idx >= 6'(NULL_LO)) && (idx <= 6'(NULL_HI)));
  endfunction

endpackage

// File: rtl/qam_mapper_if.sv
// Bit-stream input and subcarrier output bundle of the QAM mapper.
interface qam_mapper_if;
  logic               in_bit;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         mode;
  logic signed [15:0] outx;
  logic signed [15:0] outy;
  logic               mod_en;
  logic [5:0]         sym_idx;
  logic               frame_end;

  modport master (
    output in_bit, in_valid, mode,
    input  in_ready, outx, outy, mod_en, sym_idx, frame_end
  );

  modport slave (
    input  in_bit, in_valid, mode,
    output in_ready, outx, outy, mod_en, sym_idx, frame_end
  );
endinterface

// File: rtl/qam_lut.sv
// Combinational Gray-coded constellation lookup: collected bits (b0 in bit 0)
// and modulation mode to a Q1.14 I/Q point.
module qam_lut
  import ofdm_pkg::*;
#(
  parameter logic signed [15:0] AMP_BPSK  = AMP_BPSK_DEF,
  parameter logic signed [15:0] AMP_QPSK  = AMP_QPSK_DEF,
  parameter logic signed [15:0] AMP_QAM16 = AMP_QAM16_DEF
) (
  input  logic [3:0]         bits,
  input  mode_t              mode,
  output logic signed [15:0] i_val,
  output logic signed [15:0] q_val
);

  localparam logic signed [15:0] AMP_QAM16_OUT = 16'(3 * AMP_QAM16);

  // First bit of a pair picks the sign, second picks inner (1) or outer (0).
  function automatic logic signed [15:0] level16(logic sign_bit, logic inner_bit);
    if (sign_bit) return inner_bit ? AMP_QAM16 : AMP_QAM16_OUT;
    else          return inner_bit ? -AMP_QAM16 : -AMP_QAM16_OUT;
  endfunction

  always_comb begin
    i_val = '0;
    q_val = '0;
    case (mode)
      MODE_BPSK: begin
        i_val = bits[0] ? AMP_BPSK : -AMP_BPSK;
      end
      MODE_QAM16: begin
        i_val = level16(bits[0], bits[1]);
        q_val = level16(bits[2], bits[3]);
      end
      default: begin
        i_val = bits[0] ? AMP_QPSK : -AMP_QPSK;
        q_val = bits[1] ? AMP_QPSK : -AMP_QPSK;
      end
    endcase
  end

endmodule

// File: rtl/qam_mapper.sv
// Serial-bit to OFDM subcarrier mapper: groups bits per symbol, Gray-maps them
// and emits 64 indexed subcarriers per frame, inserting null carriers.
module qam_mapper
  import ofdm_pkg::*;
#(
  parameter bit                 NULL_EN   = 1'b1,
  parameter logic signed [15:0] AMP_BPSK  = AMP_BPSK_DEF,
  parameter logic signed [15:0] AMP_QPSK  = AMP_QPSK_DEF,
  parameter logic signed [15:0] AMP_QAM16 = AMP_QAM16_DEF
) (
  input  logic         clk,
  input  logic         reset,
  qam_mapper_if.slave  bus
);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t             state, state_next;
  logic [2:0]         bit_cnt;
  logic [5:0]         sym_cnt;
  logic [3:0]         shreg;
  logic [3:0]         new_bits;
  mode_t              cur_mode;
  mode_t              eff_mode;
  logic [2:0]         bps;
  logic               null_slot;
  logic               xfer;
  logic               done;
  logic               emit_null;
  logic signed [15:0] lut_i, lut_q;
  logic signed [15:0] x_r, y_r;
  logic [5:0]         idx_r;

  // The mode is only sampled from the port at a symbol boundary.
  assign eff_mode  = (bit_cnt == 3'd0) ? mode_t'(bus.mode) : cur_mode;
  assign bps       = bits_per_symbol(eff_mode);
  assign null_slot = NULL_EN && is_null_idx(sym_cnt);
  assign xfer      = bus.in_valid && bus.in_ready;
  assign done      = xfer && ((bit_cnt + 3'd1) == bps);
  assign emit_null = bus.in_valid && null_slot;

  always_comb begin
    new_bits               = shreg;
    new_bits[bit_cnt[1:0]] = bus.in_bit;
  end

  qam_lut #(
    .AMP_BPSK (AMP_BPSK),
    .AMP_QPSK (AMP_QPSK),
    .AMP_QAM16(AMP_QAM16)
  ) u_lut (
    .bits (new_bits),
    .mode (eff_mode),
    .i_val(lut_i),
    .q_val(lut_q)
  );

  // EMIT marks the cycle in which the registered point is presented.
  always_comb begin
    state_next = COLLECT;
    if (done || emit_null) state_next = EMIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      bit_cnt  <= '0;
      sym_cnt  <= '0;
      shreg    <= '0;
      cur_mode <= MODE_BPSK;
      x_r      <= '0;
      y_r      <= '0;
      idx_r    <= '0;
    end else begin
      state <= state_next;
      if (emit_null) begin
        x_r     <= '0;
        y_r     <= '0;
        idx_r   <= sym_cnt;
        sym_cnt <= sym_cnt + 6'd1;
      end else if (xfer) begin
        cur_mode <= eff_mode;
        if (done) begin
          bit_cnt <= '0;
          shreg   <= '0;
          x_r     <= lut_i;
          y_r     <= lut_q;
          idx_r   <= sym_cnt;
          sym_cnt <= sym_cnt + 6'd1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= new_bits;
        end
      end
    end
  end

  assign bus.in_ready  = !reset && !null_slot;
  assign bus.outx      = x_r;
  assign bus.outy      = y_r;
  assign bus.mod_en    = (state == EMIT);
  assign bus.sym_idx   = idx_r;
  assign bus.frame_end = bus.mod_en && (idx_r == 6'd63);

endmodule

// File: tb/tb_qam_mapper.sv
// Self-checking bench for qam_mapper: directed constellation/timing scenarios
// plus randomized streams checked against a queue-based reference model.
module tb_qam_mapper;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qam_mapper_if bus();

  qam_mapper #(.NULL_EN(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic               o_ready, o_en, o_fe;
  logic signed [15:0] o_x, o_y;
  logic [5:0]         o_idx;

  int                 m_idx;
  int                 m_mode;
  int                 m_pend[$];
  logic               e_ready, e_en, e_fe;
  logic signed [15:0] e_x, e_y;
  logic [5:0]         e_idx;

  function automatic int bps_of(int m);
    return (m == 0) ? 1 : ((m == 2) ? 4 : 2);
  endfunction

  function automatic bit is_null(int i);
    return (i == 0) || (i >= 27 && i <= 37);
  endfunction

  function automatic int qam_level(int s, int inner);
    return (s != 0 ? 1 : -1) * (inner != 0 ? 1 : 3) * 5181;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_mode = 0; m_pend.delete();
    e_x = '0; e_y = '0; e_en = 1'b0; e_fe = 1'b0; e_idx = '0;
  endtask

  // Reference behaviour for one clock given the inputs presented before the edge.
  task automatic model_step(bit v, bit b, int md);
    int xv, yv;
    e_en    = 1'b0;
    e_ready = !is_null(m_idx);
    if (v && !e_ready) begin
      e_en = 1'b1; e_x = '0; e_y = '0; e_idx = 6'(m_idx);
      m_idx = (m_idx + 1) % 64;
    end else if (v) begin
      if (m_pend.size() == 0) m_mode = (md == 3) ? 1 : md;
      m_pend.push_back(int'(b));
      if (m_pend.size() == bps_of(m_mode)) begin
        xv = 0; yv = 0;
        if (m_mode == 0) begin
          xv = m_pend[0] ? 16384 : -16384;
        end else if (m_mode == 1) begin
          xv = m_pend[0] ? 11585 : -11585;
          yv = m_pend[1] ? 11585 : -11585;
        end else begin
          xv = qam_level(m_pend[0], m_pend[1]);
          yv = qam_level(m_pend[2], m_pend[3]);
        end
        e_en = 1'b1; e_x = 16'(xv); e_y = 16'(yv); e_idx = 6'(m_idx);
        m_idx = (m_idx + 1) % 64;
        m_pend.delete();
      end
    end
    e_fe = e_en && (e_idx == 6'd63);
  endtask

  // Drives one cycle from just after a falling edge and samples on the next one.
  task automatic tick(bit v, bit b, int md);
    bus.in_valid = v; bus.in_bit = b; bus.mode = 2'(md);
    #1;
    o_ready = bus.in_ready;
    model_step(v, b, md);
    @(posedge clk);
    @(negedge clk);
    o_en = bus.mod_en; o_x = bus.outx; o_y = bus.outy;
    o_idx = bus.sym_idx; o_fe = bus.frame_end;
  endtask

  task automatic apply_reset();
    reset = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; bus.in_valid = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.mod_en !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_mod_en: got %b expected 0", bus.mod_en); end
    n_checks++;
    if (bus.outx !== 16'sd0 || bus.outy !== 16'sd0) begin n_fails++; $display("[TB] FAIL reset_xy: got %0d,%0d expected 0,0", bus.outx, bus.outy); end
    n_checks++;
    if (bus.sym_idx !== 6'd0 || bus.frame_end !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_idx_fe: got %0d,%b expected 0,0", bus.sym_idx, bus.frame_end); end
  endtask

  task automatic test_qpsk_first();
    tick(1'b1, 1'b1, 1);
    n_checks++;
    if (o_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL null0_ready: got %b expected 0", o_ready); end
    n_checks++;
    if (o_en !== 1'b1 || o_idx !== 6'd0 || o_x !== 16'sd0 || o_y !== 16'sd0) begin n_fails++;
      $display("[TB] FAIL null0_emit: got en=%b idx=%0d x=%0d y=%0d expected en=1 idx=0 x=0 y=0", o_en, o_idx, o_x, o_y); end
    tick(1'b1, 1'b1, 1);
    n_checks++;
    if (o_ready !== 1'b1 || o_en !== 1'b0) begin n_fails++; $display("[TB] FAIL qpsk_mid: got ready=%b en=%b expected ready=1 en=0", o_ready, o_en); end
    tick(1'b1, 1'b0, 1);
    n_checks++;
    if (o_en !== 1'b1 || o_idx !== 6'd1 || o_x !== 16'sd11585 || o_y !== -16'sd11585) begin n_fails++;
      $display("[TB] FAIL qpsk_point: got en=%b idx=%0d x=%0d y=%0d expected en=1 idx=1 x=11585 y=-11585", o_en, o_idx, o_x, o_y); end
  endtask

  task automatic test_qam16();
    bit seq_a[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit seq_b[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, seq_a[k], 2);
      n_checks++;
      if (o_en !== 1'b0) begin n_fails++; $display("[TB] FAIL qam16_partial_a: got en=%b expected 0 at bit %0d", o_en, k); end
    end
    tick(1'b1, seq_a[3], 2);
    n_checks++;
    if (o_en !== 1'b1 || o_idx !== 6'd2 || o_x !== 16'sd15543 || o_y !== -16'sd5181) begin n_fails++;
      $display("[TB] FAIL qam16_a: got en=%b idx=%0d x=%0d y=%0d expected en=1 idx=2 x=15543 y=-5181", o_en, o_idx, o_x, o_y); end
    for (int k = 0; k < 4; k++) tick(1'b1, seq_b[k], 2);
    n_checks++;
    if (o_en !== 1'b1 || o_idx !== 6'd3 || o_x !== -16'sd5181 || o_y !== 16'sd5181) begin n_fails++;
      $display("[TB] FAIL qam16_b: got en=%b idx=%0d x=%0d y=%0d expected en=1 idx=3 x=-5181 y=5181", o_en, o_idx, o_x, o_y); end
  endtask

  task automatic test_full_frame();
    int emits = 0, nulls = 0, fes = 0, cyc = 0;
    apply_reset();
    while (emits < 64 && cyc < 400) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 1);
      cyc++;
      n_checks++;
      if (o_ready !== e_ready || o_en !== e_en) begin n_fails++;
        $display("[TB] FAIL frame_handshake: cycle %0d got ready=%b en=%b expected ready=%b en=%b", cyc, o_ready, o_en, e_ready, e_en); end
      if (e_en) begin
        n_checks++;
        if (o_idx !== e_idx || o_x !== e_x || o_y !== e_y || o_fe !== e_fe) begin n_fails++;
          $display("[TB] FAIL frame_point: got idx=%0d x=%0d y=%0d fe=%b expected idx=%0d x=%0d y=%0d fe=%b", o_idx, o_x, o_y, o_fe, e_idx, e_x, e_y, e_fe); end
      end
      if (o_en) emits++;
      if (o_en && o_x == 16'sd0 && o_y == 16'sd0 && is_null(int'(o_idx))) nulls++;
      if (o_fe) begin
        fes++;
        n_checks++;
        if (o_idx !== 6'd63) begin n_fails++; $display("[TB] FAIL frame_end_idx: got %0d expected 63", o_idx); end
      end
    end
    n_checks++;
    if (emits != 64) begin n_fails++; $display("[TB] FAIL frame_emits: got %0d expected 64 within 400 cycles", emits); end
    n_checks++;
    if (nulls != 12 || fes != 1) begin n_fails++; $display("[TB] FAIL frame_nulls_fe: got nulls=%0d fe=%0d expected 12,1", nulls, fes); end
    tick(1'b1, 1'b0, 1);
    n_checks++;
    if (o_en !== 1'b1 || o_idx !== 6'd0 || o_fe !== 1'b0) begin n_fails++;
      $display("[TB] FAIL frame_wrap: got en=%b idx=%0d fe=%b expected en=1 idx=0 fe=0", o_en, o_idx, o_fe); end
  endtask

  task automatic test_mode_switch();
    apply_reset();
    tick(1'b1, 1'b0, 1);
    tick(1'b1, 1'b1, 1);
    tick(1'b1, 1'b1, 0);
    n_checks++;
    if (o_en !== 1'b1 || o_idx !== 6'd1 || o_x !== 16'sd11585 || o_y !== 16'sd11585) begin n_fails++;
      $display("[TB] FAIL switch_qpsk: got en=%b idx=%0d x=%0d y=%0d expected en=1 idx=1 x=11585 y=11585", o_en, o_idx, o_x, o_y); end
    tick(1'b1, 1'b0, 0);
    n_checks++;
    if (o_en !== 1'b1 || o_idx !== 6'd2 || o_x !== -16'sd16384 || o_y !== 16'sd0) begin n_fails++;
      $display("[TB] FAIL switch_bpsk: got en=%b idx=%0d x=%0d y=%0d expected en=1 idx=2 x=-16384 y=0", o_en, o_idx, o_x, o_y); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 20; k++) tick(1'b1, 1'($urandom_range(0, 1)), 0);
    tick(1'b1, 1'b1, 2);
    n_checks++;
    if (o_en !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_partial: got en=%b expected 0", o_en); end
    reset = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.mod_en !== 1'b0 || bus.sym_idx !== 6'd0 || bus.outx !== 16'sd0) begin n_fails++;
      $display("[TB] FAIL mid_reset: got en=%b idx=%0d x=%0d expected en=0 idx=0 x=0", bus.mod_en, bus.sym_idx, bus.outx); end
    reset = 1'b0;
    model_reset();
    tick(1'b1, 1'b0, 2);
    n_checks++;
    if (o_en !== 1'b1 || o_idx !== 6'd0) begin n_fails++; $display("[TB] FAIL mid_null0: got en=%b idx=%0d expected en=1 idx=0", o_en, o_idx); end
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 2);
    n_checks++;
    if (o_en !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_stale_bits: got en=%b expected 0 after 3 bits", o_en); end
    tick(1'b1, 1'b0, 2);
    n_checks++;
    if (o_en !== 1'b1 || o_idx !== 6'd1 || o_x !== -16'sd15543 || o_y !== -16'sd15543) begin n_fails++;
      $display("[TB] FAIL mid_first: got en=%b idx=%0d x=%0d y=%0d expected en=1 idx=1 x=-15543 y=-15543", o_en, o_idx, o_x, o_y); end
  endtask

  task automatic test_gaps();
    bit bits[40];
    logic [37:0] ref_q[$];
    logic [37:0] gap_q[$];
    int k, cyc;
    bit v;
    for (int i = 0; i < 40; i++) bits[i] = 1'($urandom_range(0, 1));
    apply_reset();
    k = 0; cyc = 0;
    while (k < 40 && cyc < 200) begin
      tick(1'b1, bits[k], 0);
      cyc++;
      if (o_ready) k++;
      if (o_en) ref_q.push_back({o_idx, o_x, o_y});
    end
    apply_reset();
    k = 0; cyc = 0;
    while (k < 40 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      tick(v, bits[k], 0);
      cyc++;
      if (v && o_ready) k++;
      n_checks++;
      if (o_en !== e_en || (e_en && (o_idx !== e_idx || o_x !== e_x || o_y !== e_y))) begin n_fails++;
        $display("[TB] FAIL gap_cycle: cycle %0d valid=%b got en=%b idx=%0d x=%0d expected en=%b idx=%0d x=%0d", cyc, v, o_en, o_idx, o_x, e_en, e_idx, e_x); end
      if (!v) begin
        n_checks++;
        if (o_en !== 1'b0) begin n_fails++; $display("[TB] FAIL gap_idle_emit: got en=%b expected 0 with in_valid low", o_en); end
      end
      if (o_en) gap_q.push_back({o_idx, o_x, o_y});
    end
    n_checks++;
    if (k != 40 || gap_q.size() != ref_q.size()) begin n_fails++;
      $display("[TB] FAIL gap_count: got bits=%0d emits=%0d expected bits=40 emits=%0d", k, gap_q.size(), ref_q.size()); end
    else begin
      for (int i = 0; i < ref_q.size(); i++) begin
        n_checks++;
        if (gap_q[i] !== ref_q[i]) begin n_fails++; $display("[TB] FAIL gap_seq: entry %0d got %h expected %h", i, gap_q[i], ref_q[i]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.mode = 2'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_qpsk_first();
    test_qam16();
    test_full_frame();
    test_mode_switch();
    test_reset_mid();
    test_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
